regfile_scan_checker: RTL and testbench

- Synthesizable end-of-run checker placed downstream of the processor/regfile pair; turns the bench's register-dump check into hardware.
- Monitors regfile write-back traffic for a programmed number of cycles.
- Then takes over regfile read port A and compares all registers against an expected-value ROM.
- Reports error count, first failing register and a pass flag. Lets FPGA builds self-check without a simulator.

---
 rtl/regfile_scan_checker.sv | 184 ++++++++++++++++++
 tb/tb_regfile_scan_checker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scan_checker.sv
// End-of-run regfile checker: counts write-backs for a programmed run length, then scans
// every register through read port A against an expected-value ROM. Optional trace FIFO: REGFILE_SCAN_TRACE_EN.
module regfile_scan_checker #(
  parameter int NUM_REGS = 32,
  parameter int CYCLE_W  = 8,
  parameter int WCNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CYCLE_W-1:0]   num_cycles,
  input  logic                 rwe,
  input  logic [4:0]           rd,
  input  logic [31:0]          rData,
  input  logic [4:0]           cpu_rs1,
  output logic [4:0]           rs1_out,
  input  logic [31:0]          regA,
  output logic [4:0]           exp_addr,
  input  logic [31:0]          exp_data,
  output logic                 test_mode,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [5:0]           errors,
  output logic [4:0]           fail_reg,
  output logic                 fail_valid,
  output logic [WCNT_W-1:0]    write_count,
  output logic [CYCLE_W-1:0]   cycles,
  output logic                 trace_valid,
  output logic [CYCLE_W+36:0]  trace_data,
  input  logic                 trace_pop,
  output logic                 trace_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t             state;
  logic [CYCLE_W-1:0] latched_n;
  logic [31:0]        sample_data;
  logic [4:0]         sample_idx;
  logic               cmp_valid;
  logic               draining;

  logic       accept;
  logic       count_write;
  logic       mismatch;
  logic [5:0] errors_next;

  assign accept      = start && (state == IDLE || state == DONE);
  assign count_write = (state == RUN) && rwe && (rd != 5'd0);
  // The ROM output for the register sampled last clock arrives this clock.
  assign mismatch    = (state == SCAN) && cmp_valid && (exp_data != sample_data);
  assign errors_next = errors + 6'(mismatch);

  assign busy    = (state == RUN) || (state == SCAN);
  assign rs1_out = test_mode ? exp_addr : cpu_rs1;

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking assignments would make results depend on statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      latched_n   <= '0;
      cycles      <= '0;
      write_count <= '0;
      errors      <= '0;
      fail_reg    <= '0;
      fail_valid  <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      test_mode   <= 1'b0;
      exp_addr    <= '0;
      sample_data <= '0;
      sample_idx  <= '0;
      cmp_valid   <= 1'b0;
      draining    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            latched_n   <= num_cycles;
            cycles      <= '0;
            write_count <= '0;
            errors      <= '0;
            fail_reg    <= '0;
            fail_valid  <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
          end
        end
        RUN: begin
          if (count_write && write_count != {WCNT_W{1'b1}})
            write_count <= write_count + WCNT_W'(1);
          // Leaving RUN leaves cycles equal to the run length (0 stays 0).
          if (latched_n == '0 || cycles == latched_n - CYCLE_W'(1)) begin
            state     <= SCAN;
            cycles    <= latched_n;
            test_mode <= 1'b1;
            exp_addr  <= '0;
            cmp_valid <= 1'b0;
            draining  <= 1'b0;
          end else begin
            cycles <= cycles + CYCLE_W'(1);
          end
        end
        SCAN: begin
          errors <= errors_next;
          if (mismatch && !fail_valid) begin
            fail_reg   <= sample_idx;
            fail_valid <= 1'b1;
          end
          if (!draining) begin
            sample_data <= regA;
            sample_idx  <= exp_addr;
            cmp_valid   <= 1'b1;
            if (exp_addr == LAST_IDX) draining <= 1'b1;
            else                      exp_addr <= exp_addr + 5'd1;
          end else begin
            // Extra clock only finishes the last register's compare.
            cmp_valid <= 1'b0;
            draining  <= 1'b0;
            test_mode <= 1'b0;
            state     <= DONE;
            done      <= 1'b1;
            pass      <= (errors_next == 6'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REGFILE_SCAN_TRACE_EN
  localparam int TW = CYCLE_W + 37;

  logic [TW-1:0] fifo_mem [16];
  logic [3:0]    wr_ptr;
  logic [3:0]    rd_ptr;
  logic [4:0]    fifo_cnt;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;

  assign fifo_full = (fifo_cnt == 5'd16);
  assign do_pop    = trace_pop && (fifo_cnt != 5'd0);
  assign do_push   = count_write && (!fifo_full || do_pop);

  assign trace_valid = (fifo_cnt != 5'd0);
  assign trace_data  = fifo_mem[rd_ptr];

  // NOTE: the storage array has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) fifo_mem[wr_ptr] <= {cycles, rd, rData};
  end

  always_ff @(posedge clock) begin
    if (reset || accept) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      trace_ovf <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 4'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 4'd1;
      case ({do_push, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 5'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 5'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (count_write && !do_push) trace_ovf <= 1'b1;
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^{trace_pop, rData};
  assign trace_valid  = 1'b0;
  assign trace_data   = '0;
  assign trace_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Directed bench for regfile_scan_checker: regfile and ROM are modelled as arrays in the bench;
// the trace FIFO scenario is compiled only with REGFILE_SCAN_TRACE_EN.
module tb_regfile_scan_checker;
  localparam int NUM_REGS = 32;
  localparam int CYCLE_W  = 8;
  localparam int WCNT_W   = 16;
  localparam int TW       = CYCLE_W + 37;

  logic               clock = 1'b0;
  logic               reset, start, rwe, trace_pop;
  logic [CYCLE_W-1:0] num_cycles;
  logic [4:0]         rd, cpu_rs1, rs1_out, exp_addr, fail_reg;
  logic [31:0]        rData, regA, exp_data;
  logic               test_mode, busy, done, pass, fail_valid, trace_valid, trace_ovf;
  logic [5:0]         errors;
  logic [WCNT_W-1:0]  write_count;
  logic [CYCLE_W-1:0] cycles;
  logic [TW-1:0]      trace_data;

  logic [31:0] reg_mem [NUM_REGS];
  logic [31:0] rom     [NUM_REGS];

  int checks   = 0;
  int failures = 0;

  regfile_scan_checker #(.NUM_REGS(NUM_REGS), .CYCLE_W(CYCLE_W), .WCNT_W(WCNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .rwe(rwe), .rd(rd), .rData(rData), .cpu_rs1(cpu_rs1), .rs1_out(rs1_out),
    .regA(regA), .exp_addr(exp_addr), .exp_data(exp_data), .test_mode(test_mode),
    .busy(busy), .done(done), .pass(pass), .errors(errors), .fail_reg(fail_reg),
    .fail_valid(fail_valid), .write_count(write_count), .cycles(cycles),
    .trace_valid(trace_valid), .trace_data(trace_data), .trace_pop(trace_pop),
    .trace_ovf(trace_ovf)
  );

  always #5 clock = ~clock;

  // Combinational regfile read port A and a one-clock-latency ROM.
  assign regA = reg_mem[rs1_out];
  always @(posedge clock) exp_data <= rom[exp_addr];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_identical();
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_mem[i] = 32'd0;
      rom[i]     = 32'd0;
    end
    reg_mem[1] = 32'd5; rom[1] = 32'd5;
    reg_mem[2] = 32'd7; rom[2] = 32'd7;
  endtask

  task automatic start_run(input logic [CYCLE_W-1:0] n);
    num_cycles = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // lat = clocks after the accepting edge at which done was first seen, -1 if the budget ran out.
  task automatic wait_done(input int budget, input int elapsed, output int lat);
    lat = -1;
    for (int k = elapsed + 1; k <= elapsed + budget; k++) begin
      tick();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rwe = 1'b0; rd = 5'd0; rData = 32'd0;
    trace_pop = 1'b0; num_cycles = '0; cpu_rs1 = 5'd7;
    load_identical();
    tick(); tick();
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done got=%0h exp=0", done); end
    checks++; if (pass !== 1'b0)       begin failures++; $display("FAIL reset_pass got=%0h exp=0", pass); end
    checks++; if (test_mode !== 1'b0)  begin failures++; $display("FAIL reset_test_mode got=%0h exp=0", test_mode); end
    checks++; if (fail_valid !== 1'b0) begin failures++; $display("FAIL reset_fail_valid got=%0h exp=0", fail_valid); end
    checks++; if (errors !== 6'd0)     begin failures++; $display("FAIL reset_errors got=%0d exp=0", errors); end
    checks++; if (fail_reg !== 5'd0)   begin failures++; $display("FAIL reset_fail_reg got=%0d exp=0", fail_reg); end
    checks++; if (write_count !== '0)  begin failures++; $display("FAIL reset_write_count got=%0d exp=0", write_count); end
    checks++; if (cycles !== '0)       begin failures++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
    checks++; if (exp_addr !== 5'd0)   begin failures++; $display("FAIL reset_exp_addr got=%0d exp=0", exp_addr); end
    checks++; if (rs1_out !== 5'd7)    begin failures++; $display("FAIL reset_rs1_out got=%0d exp=7", rs1_out); end
    checks++; if (trace_valid !== 1'b0 || trace_ovf !== 1'b0) begin failures++; $display("FAIL reset_trace got=%0h/%0h exp=0/0", trace_valid, trace_ovf); end
    reset = 1'b0;
    tick();
    cpu_rs1 = 5'd19;
    #1;
    checks++; if (rs1_out !== 5'd19)   begin failures++; $display("FAIL idle_rs1_passthru got=%0d exp=19", rs1_out); end
  endtask

  task automatic test_normal_run();
    int lat;
    load_identical();
    cpu_rs1 = 5'd9;
    #1;
    checks++; if (rs1_out !== 5'd9) begin failures++; $display("FAIL pre_scan_rs1 got=%0d exp=9", rs1_out); end
    start_run(8'd10);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL run_busy got=%0h exp=1", busy); end
    for (int k = 1; k <= 9; k++) tick();
    checks++; if (test_mode !== 1'b0 || cycles !== 8'd9) begin failures++; $display("FAIL run_last_clock tm=%0h cyc=%0d exp tm=0 cyc=9", test_mode, cycles); end
    tick();
    checks++; if (test_mode !== 1'b1 || rs1_out !== 5'd0) begin failures++; $display("FAIL scan_entry tm=%0h rs1=%0d exp tm=1 rs1=0", test_mode, rs1_out); end
    for (int k = 11; k <= 15; k++) tick();
    checks++; if (rs1_out !== 5'd5 || exp_addr !== 5'd5) begin failures++; $display("FAIL scan_idx rs1=%0d addr=%0d exp 5/5", rs1_out, exp_addr); end
    wait_done(100, 15, lat);
    checks++; if (lat !== 43)         begin failures++; $display("FAIL normal_latency got=%0d exp=43", lat); end
    checks++; if (errors !== 6'd0)    begin failures++; $display("FAIL normal_errors got=%0d exp=0", errors); end
    checks++; if (pass !== 1'b1)      begin failures++; $display("FAIL normal_pass got=%0h exp=1", pass); end
    checks++; if (fail_valid !== 1'b0) begin failures++; $display("FAIL normal_fail_valid got=%0h exp=0", fail_valid); end
    checks++; if (cycles !== 8'd10)   begin failures++; $display("FAIL normal_cycles got=%0d exp=10", cycles); end
    checks++; if (test_mode !== 1'b0 || busy !== 1'b0 || rs1_out !== 5'd9) begin failures++; $display("FAIL post_scan tm=%0h busy=%0h rs1=%0d exp 0/0/9", test_mode, busy, rs1_out); end
  endtask

  task automatic test_mismatch();
    int lat;
    load_identical();
    rom[5]  = 32'd99;
    rom[17] = 32'd1;
    start_run(8'd3);
    wait_done(100, 0, lat);
    checks++; if (lat !== 36)          begin failures++; $display("FAIL mismatch_latency got=%0d exp=36", lat); end
    checks++; if (errors !== 6'd2)     begin failures++; $display("FAIL mismatch_errors got=%0d exp=2", errors); end
    checks++; if (fail_reg !== 5'd5)   begin failures++; $display("FAIL mismatch_fail_reg got=%0d exp=5", fail_reg); end
    checks++; if (fail_valid !== 1'b1) begin failures++; $display("FAIL mismatch_fail_valid got=%0h exp=1", fail_valid); end
    checks++; if (pass !== 1'b0)       begin failures++; $display("FAIL mismatch_pass got=%0h exp=0", pass); end
    tick(); tick();
    checks++; if (done !== 1'b1 || errors !== 6'd2) begin failures++; $display("FAIL done_hold done=%0h err=%0d exp 1/2", done, errors); end
  endtask

  task automatic test_restart_from_done();
    int lat;
    load_identical();
    start_run(8'd2);
    checks++; if (done !== 1'b0 || errors !== 6'd0 || fail_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL restart_clear done=%0h err=%0d fv=%0h busy=%0h exp 0/0/0/1", done, errors, fail_valid, busy);
    end
    wait_done(100, 0, lat);
    checks++; if (lat !== 35 || pass !== 1'b1) begin failures++; $display("FAIL restart_result lat=%0d pass=%0h exp 35/1", lat, pass); end
  endtask

  task automatic test_write_count();
    int lat;
    load_identical();
    rwe = 1'b1; rd = 5'd4; rData = 32'hdead;
    tick();
    rwe = 1'b0;
    start_run(8'd10);
    checks++; if (write_count !== '0) begin failures++; $display("FAIL wc_after_accept got=%0d exp=0", write_count); end
    for (int k = 1; k <= 14; k++) begin
      rwe = (k <= 5) || (k >= 12);
      rd  = (k <= 3) ? 5'd3 : (k <= 5) ? 5'd0 : 5'd6;
      tick();
    end
    rwe = 1'b0;
    wait_done(100, 14, lat);
    checks++; if (write_count !== 16'd3) begin failures++; $display("FAIL write_count got=%0d exp=3", write_count); end
    checks++; if (lat !== 43)            begin failures++; $display("FAIL wc_latency got=%0d exp=43", lat); end
  endtask

  task automatic test_zero_cycles();
    int lat;
    load_identical();
    start_run(8'd0);
    tick();
    checks++; if (test_mode !== 1'b1 || cycles !== 8'd0) begin failures++; $display("FAIL zero_scan_entry tm=%0h cyc=%0d exp 1/0", test_mode, cycles); end
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (test_mode !== 1'b1 || exp_addr !== 5'd4) begin failures++; $display("FAIL start_in_scan tm=%0h addr=%0d exp 1/4", test_mode, exp_addr); end
    wait_done(100, 5, lat);
    checks++; if (lat !== 34)       begin failures++; $display("FAIL zero_latency got=%0d exp=34", lat); end
    checks++; if (cycles !== 8'd0)  begin failures++; $display("FAIL zero_cycles got=%0d exp=0", cycles); end
    checks++; if (pass !== 1'b1)    begin failures++; $display("FAIL zero_pass got=%0h exp=1", pass); end
  endtask

  task automatic test_reset_mid_scan();
    load_identical();
    rom[5] = 32'd99;
    cpu_rs1 = 5'd21;
    start_run(8'd0);
    for (int k = 1; k <= 13; k++) tick();
    checks++; if (exp_addr !== 5'd12 || errors !== 6'd1) begin failures++; $display("FAIL pre_reset addr=%0d err=%0d exp 12/1", exp_addr, errors); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || test_mode !== 1'b0 || errors !== 6'd0 || done !== 1'b0 || rs1_out !== 5'd21) begin
      failures++; $display("FAIL mid_scan_reset busy=%0h tm=%0h err=%0d done=%0h rs1=%0d exp 0/0/0/0/21", busy, test_mode, errors, done, rs1_out);
    end
    tick(); tick();
    checks++; if (busy !== 1'b0 || exp_addr !== 5'd0) begin failures++; $display("FAIL stays_idle busy=%0h addr=%0d exp 0/0", busy, exp_addr); end
  endtask

`ifdef REGFILE_SCAN_TRACE_EN
  task automatic test_trace();
    int lat;
    int npop;
    logic [TW-1:0] exp_e;
    logic [TW-1:0] last_e;
    load_identical();
    start_run(8'd20);
    for (int k = 1; k <= 17; k++) begin
      rwe = 1'b1; rd = 5'(k); rData = 32'(k * 100);
      tick();
    end
    rwe = 1'b0;
    checks++; if (trace_ovf !== 1'b1 || trace_valid !== 1'b1) begin failures++; $display("FAIL trace_full ovf=%0h valid=%0h exp 1/1", trace_ovf, trace_valid); end
    for (int i = 1; i <= 16; i++) begin
      exp_e = {8'(i - 1), 5'(i), 32'(i * 100)};
      checks++; if (trace_data !== exp_e) begin failures++; $display("FAIL trace_entry%0d got=%0h exp=%0h", i, trace_data, exp_e); end
      trace_pop = 1'b1;
      tick();
      trace_pop = 1'b0;
    end
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL trace_drained got=%0h exp=0", trace_valid); end
    wait_done(200, 33, lat);
    checks++; if (lat !== 53) begin failures++; $display("FAIL trace_latency got=%0d exp=53", lat); end

    start_run(8'd20);
    checks++; if (trace_ovf !== 1'b0 || trace_valid !== 1'b0) begin failures++; $display("FAIL trace_clear ovf=%0h valid=%0h exp 0/0", trace_ovf, trace_valid); end
    for (int k = 1; k <= 17; k++) begin
      rwe = 1'b1; rd = 5'(k); rData = 32'(k * 100);
      trace_pop = (k == 17);
      tick();
    end
    rwe = 1'b0; trace_pop = 1'b0;
    exp_e = {8'd1, 5'd2, 32'd200};
    checks++; if (trace_ovf !== 1'b0)   begin failures++; $display("FAIL trace_pushpop_ovf got=%0h exp=0", trace_ovf); end
    checks++; if (trace_data !== exp_e) begin failures++; $display("FAIL trace_pushpop_head got=%0h exp=%0h", trace_data, exp_e); end
    npop = 0;
    last_e = '0;
    for (int i = 0; i < 20; i++) begin
      if (trace_valid !== 1'b1) break;
      last_e = trace_data;
      npop++;
      trace_pop = 1'b1;
      tick();
      trace_pop = 1'b0;
    end
    exp_e = {8'd16, 5'd17, 32'd1700};
    checks++; if (npop !== 16)          begin failures++; $display("FAIL trace_pushpop_count got=%0d exp=16", npop); end
    checks++; if (last_e !== exp_e)     begin failures++; $display("FAIL trace_pushpop_tail got=%0h exp=%0h", last_e, exp_e); end
    wait_done(200, 33, lat);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL trace_run2_done got=%0h exp=1", done); end
  endtask
`endif

  initial begin
    test_reset();
    test_normal_run();
    test_mismatch();
    test_restart_from_done();
    test_write_count();
    test_zero_cycles();
    test_reset_mid_scan();
`ifdef REGFILE_SCAN_TRACE_EN
    test_trace();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
